alu_mul_sequencer: RTL

//  Iterative shift-add multiplier controller (RV32M MUL, low 32 bits) that borrows the

---
 rtl/alu_mul_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL (low 32 bits) sequencer that time-shares the core's combinational ALU.
// Define ALU_MUL_EARLY_TERM_EN to stop as soon as no multiplier bits remain.
module alu_mul_sequencer #(
  parameter int unsigned ITER       = 32,
  parameter logic [3:0]  ALU_OP_ADD = 4'b0000,
  parameter logic [3:0]  ALU_OP_SLL = 4'b0111
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_multiplicand,
  input  logic [31:0] i_multiplier,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product,
  output logic [31:0] o_aluOpA,
  output logic [31:0] o_aluOpB,
  output logic [3:0]  o_aluOp,
  input  logic [31:0] i_aluData
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  localparam logic [5:0] ITER_C = 6'(ITER);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] product_q, product_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mplier_sh;
  logic [5:0]  cnt_inc;
  logic        last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    o_aluOpA  = '0;
    o_aluOpB  = '0;
    o_aluOp   = ALU_OP_ADD;
    mplier_sh = mplier_q >> 1;
    cnt_inc   = cnt_q + 6'd1;
    last      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          acc_d    = '0;
          mcand_d  = i_multiplicand;
          mplier_d = i_multiplier;
          cnt_d    = '0;
`ifdef ALU_MUL_EARLY_TERM_EN
          if (i_multiplier == '0) begin
            state_d   = S_DONE;
            product_d = '0;
          end else begin
            state_d = i_multiplier[0] ? S_ADD : S_SHIFT;
          end
`else
          state_d = i_multiplier[0] ? S_ADD : S_SHIFT;
`endif
        end
      end
      S_ADD: begin
        o_aluOpA = acc_q;
        o_aluOpB = mcand_q;
        o_aluOp  = ALU_OP_ADD;
        acc_d    = i_aluData;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        o_aluOpA = mcand_q;
        o_aluOpB = 32'd1;
        o_aluOp  = ALU_OP_SLL;
        mcand_d  = i_aluData;
        mplier_d = mplier_sh;
        cnt_d    = cnt_inc;
        last     = (cnt_inc == ITER_C);
`ifdef ALU_MUL_EARLY_TERM_EN
        last     = last || (mplier_sh == '0);
`endif
        // acc is already final here: every ADD precedes its SHIFT
        if (last) begin
          state_d   = S_DONE;
          product_d = acc_q;
        end else begin
          state_d = mplier_sh[0] ? S_ADD : S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign o_done    = (state_q == S_DONE);
  assign o_product = product_q;

endmodule
